// File: rtl/cdb_pkg.sv
// Shared common-data-bus definitions: default widths, the no-dependency ROB tag
// and the layout of a queued CDB entry {rob_index, value, next_pc}.
package cdb_pkg;

  localparam int ROB_WIDTH   = 4;
  localparam int ADDR_WIDTH  = 32;
  localparam int VALUE_WIDTH = 32;

  // ROB tag reserved to mean "operand has no pending producer"
  localparam int NON_DEP = (1 << ROB_WIDTH) - 1;

  typedef struct packed {
    logic [ROB_WIDTH-1:0]   rob_index;
    logic [VALUE_WIDTH-1:0] value;
    logic [ADDR_WIDTH-1:0]  next_pc;
  } cdb_entry_t;

  // Flattened entry: next_pc in the low bits, value above it, rob_index on top.
  function automatic int entry_width(input int rob_w, input int addr_w);
    return rob_w + VALUE_WIDTH + addr_w;
  endfunction

  function automatic int value_lsb(input int addr_w);
    return addr_w;
  endfunction

  function automatic int rob_lsb(input int addr_w);
    return addr_w + VALUE_WIDTH;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-channel and broadcast bundle of the CDB arbiter; slave = arbiter side,
// master = producers plus CDB consumers.
interface cdb_arbiter_if #(
  parameter int NUM_SRC    = 2,
  parameter int ROB_WIDTH  = cdb_pkg::ROB_WIDTH,
  parameter int ADDR_WIDTH = cdb_pkg::ADDR_WIDTH
);
  localparam int SRC_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]            src_valid;
  logic [NUM_SRC-1:0]            src_ready;
  logic [NUM_SRC*ROB_WIDTH-1:0]  src_rob_index;
  logic [NUM_SRC*32-1:0]         src_value;
  logic [NUM_SRC*ADDR_WIDTH-1:0] src_next_pc;

  logic                  cdb_valid;
  logic [ROB_WIDTH-1:0]  cdb_rob_index;
  logic [31:0]           cdb_value;
  logic [ADDR_WIDTH-1:0] cdb_next_pc;
  logic [SRC_W-1:0]      cdb_src_id;

  modport master (
    output src_valid, src_rob_index, src_value, src_next_pc,
    input  src_ready, cdb_valid, cdb_rob_index, cdb_value, cdb_next_pc, cdb_src_id
  );

  modport slave (
    input  src_valid, src_rob_index, src_value, src_next_pc,
    output src_ready, cdb_valid, cdb_rob_index, cdb_value, cdb_next_pc, cdb_src_id
  );
endinterface

// File: rtl/cdb_fifo.sv
// Per-channel result queue; the head is read combinationally so the arbiter can
// pop and register it onto the bus in the same cycle.
module cdb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  // A full queue never takes a push, even alongside a pop; flush wins over both.
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (push_ok && !pop_ok)      count_reg <= count_reg + CNT_W'(1);
      else if (!push_ok && pop_ok) count_reg <= count_reg - CNT_W'(1);
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: queues results from NUM_SRC producers and broadcasts
// one per cycle, chosen round-robin after the last granted channel.
module cdb_arbiter #(
  parameter int NUM_SRC    = 2,
  parameter int ROB_WIDTH  = cdb_pkg::ROB_WIDTH,
  parameter int ADDR_WIDTH = cdb_pkg::ADDR_WIDTH,
  parameter int QDEPTH     = 2
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         rdy_in,
  input  logic         flush_in,
  cdb_arbiter_if.slave bus
);
  localparam int SRC_W   = $clog2(NUM_SRC);
  localparam int VW      = cdb_pkg::VALUE_WIDTH;
  localparam int ENTRY_W = cdb_pkg::entry_width(ROB_WIDTH, ADDR_WIDTH);
  localparam int VAL_LSB = cdb_pkg::value_lsb(ADDR_WIDTH);
  localparam int ROB_LSB = cdb_pkg::rob_lsb(ADDR_WIDTH);

  logic [NUM_SRC-1:0]    push;
  logic [NUM_SRC-1:0]    pop;
  logic [NUM_SRC-1:0]    empty;
  logic [NUM_SRC-1:0]    full;
  logic [ENTRY_W-1:0]    head [NUM_SRC];
  logic [ENTRY_W-1:0]    head_sel;
  logic                  grant_valid;
  logic [SRC_W-1:0]      grant_id;
  logic [SRC_W-1:0]      cand;
  logic                  advance;

  logic [SRC_W-1:0]      last_grant_reg;
  logic                  cdb_valid_reg;
  logic [ROB_WIDTH-1:0]  cdb_rob_index_reg;
  logic [VW-1:0]         cdb_value_reg;
  logic [ADDR_WIDTH-1:0] cdb_next_pc_reg;
  logic [SRC_W-1:0]      cdb_src_id_reg;

  assign advance       = rdy_in & ~flush_in;
  assign bus.src_ready = ~full;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_chan
      assign push[gi] = bus.src_valid[gi] & ~full[gi] & advance;
      assign pop[gi]  = grant_valid & (grant_id == SRC_W'(gi)) & advance;

      cdb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QDEPTH)
      ) u_fifo (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .flush (flush_in & rdy_in),
        .push  (push[gi]),
        .pop   (pop[gi]),
        .din   ({bus.src_rob_index[gi*ROB_WIDTH +: ROB_WIDTH],
                 bus.src_value[gi*VW +: VW],
                 bus.src_next_pc[gi*ADDR_WIDTH +: ADDR_WIDTH]}),
        .dout  (head[gi]),
        .empty (empty[gi]),
        .full  (full[gi])
      );
    end
  endgenerate

  // Scan starting just after the last winner; the first non-empty channel wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = SRC_W'((int'(last_grant_reg) + k) % NUM_SRC);
      if (!grant_valid && !empty[cand]) begin
        grant_valid = 1'b1;
        grant_id    = cand;
      end
    end
  end

  assign head_sel = head[grant_id];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cdb_valid_reg     <= 1'b0;
      cdb_rob_index_reg <= '0;
      cdb_value_reg     <= '0;
      cdb_next_pc_reg   <= '0;
      cdb_src_id_reg    <= '0;
      last_grant_reg    <= SRC_W'(NUM_SRC - 1);
    end else if (!rdy_in) begin
      cdb_valid_reg <= 1'b0;
    end else if (flush_in) begin
      cdb_valid_reg  <= 1'b0;
      last_grant_reg <= SRC_W'(NUM_SRC - 1);
    end else if (grant_valid) begin
      cdb_valid_reg     <= 1'b1;
      cdb_rob_index_reg <= head_sel[ROB_LSB +: ROB_WIDTH];
      cdb_value_reg     <= head_sel[VAL_LSB +: VW];
      cdb_next_pc_reg   <= head_sel[0 +: ADDR_WIDTH];
      cdb_src_id_reg    <= grant_id;
      last_grant_reg    <= grant_id;
    end else begin
      // Payload keeps its last value; only the strobe drops.
      cdb_valid_reg <= 1'b0;
    end
  end

  assign bus.cdb_valid     = cdb_valid_reg;
  assign bus.cdb_rob_index = cdb_rob_index_reg;
  assign bus.cdb_value     = cdb_value_reg;
  assign bus.cdb_next_pc   = cdb_next_pc_reg;
  assign bus.cdb_src_id    = cdb_src_id_reg;
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2: number of producer channels (RS, LSB, ...), legal values 2..8.
REQ-002 SHALL have parameter ROB_WIDTH, default 4: ROB index width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32: next-pc width.
REQ-004 SHALL have parameter QDEPTH, default 2: per-channel queue depth, a power of two and at least 2.
REQ-005 SHALL have port clk_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n_in, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port rdy_in, input, 1 bit: global enable; low freezes the block.
REQ-008 SHALL have port flush_in, input, 1 bit: mispredict flush that discards all pending results.
REQ-009 SHALL have port src_valid, input, NUM_SRC bits: per-channel result-valid.
REQ-010 SHALL have port src_ready, output, NUM_SRC bits: per-channel accept.
REQ-011 SHALL have port src_rob_index, input, NUM_SRC*ROB_WIDTH bits: flattened ROB index; channel i occupies slice i.
REQ-012 SHALL have port src_value, input, NUM_SRC*32 bits: flattened result value.
REQ-013 SHALL have port src_next_pc, input, NUM_SRC*ADDR_WIDTH bits: flattened next pc.
REQ-014 SHALL have port cdb_valid, output, 1 bit: broadcast strobe, high for exactly one cycle per result.
REQ-015 SHALL have port cdb_rob_index, output, ROB_WIDTH bits: broadcast ROB index.
REQ-016 SHALL have port cdb_value, output, 32 bits: broadcast value.
REQ-017 SHALL have port cdb_next_pc, output, ADDR_WIDTH bits: broadcast next pc.
REQ-018 SHALL have port cdb_src_id, output, clog2(NUM_SRC) bits: channel that produced the broadcast.

Function
REQ-019 SHALL give each channel a FIFO of QDEPTH entries holding {rob_index, value, next_pc}.
REQ-020 SHALL drive src_ready[i] = (count_i < QDEPTH) from registered state only: no combinational path from src_valid, and a full queue does not accept a push in the same cycle as a pop.
REQ-021 SHALL push channel i when src_valid[i] & src_ready[i] & rdy_in & !flush_in.
REQ-022 SHALL, each cycle with rdy_in=1 and flush_in=0, grant one non-empty channel by round-robin starting at channel (last_grant+1) mod NUM_SRC, pop its head and register it onto the cdb_* outputs.
REQ-023 SHALL have a minimum latency of 2 cycles from handshake to broadcast: acceptance at edge t, cdb_valid high in the cycle after edge t+1.
REQ-024 SHALL sustain a throughput of one broadcast per cycle while any queue is non-empty.
REQ-025 SHALL update last_grant only when a grant occurs.
REQ-026 SHALL register cdb_valid=0 at the next edge when no queue is non-empty, while holding the cdb payload outputs at their last values.
REQ-027 SHALL, while rdy_in=0, perform no push, no pop and no last_grant change, and register cdb_valid=0.
REQ-028 SHALL, on flush_in=1, empty every queue and set last_grant=NUM_SRC-1 (so channel 0 has first priority) and cdb_valid=0 at that edge; flush overrides a simultaneous push or pop.
REQ-029 SHALL wrap FIFO pointers modulo QDEPTH; count SHALL range 0..QDEPTH and never overflow or underflow.
REQ-030 SHALL, in the same cycle on the same channel, apply both a push and a pop when not full, leaving count unchanged.

Reset
REQ-031 SHALL, while rst_n_in=0, asynchronously clear all counts and pointers, set last_grant=NUM_SRC-1, and drive cdb_valid=0 and cdb_rob_index, cdb_value, cdb_next_pc and cdb_src_id to 0.
REQ-032 SHALL drive src_ready all-ones after reset.
REQ-033 SHALL make reset asserted mid-operation discard all queued results, with no broadcast in the first cycle after release.

Structure
REQ-034 SHALL place ROB_WIDTH, ADDR_WIDTH, NON_DEP and the CDB entry field layout in the shared cdb_pkg header/package.
REQ-035 SHALL implement the per-channel queue as sub-module cdb_fifo (parameters WIDTH, DEPTH), instantiated NUM_SRC times.
REQ-036 SHALL keep arbitration and output registers in cdb_arbiter.

Verification
REQ-037 SHALL cover single push: ch0 pushes rob=3 and value=0x12345678 at edge 1 -> cdb_valid in the cycle after edge 2 with rob=3, value=0x12345678, src_id=0, then cdb_valid=0.
REQ-038 SHALL cover fairness: NUM_SRC=2, both channels push every cycle for 8 cycles -> src_id alternates 0,1,0,1 with no channel granted twice consecutively while the other is pending.
REQ-039 SHALL cover full queue: QDEPTH=2, ch1 pushes 3 results while ch0 monopolises grants -> src_ready[1]=0 after 2 accepts, and the third result is accepted only after a ch1 pop.
REQ-040 SHALL cover flush: 3 pending entries plus flush_in with a simultaneous push -> no cdb_valid afterwards, all src_ready=1, and the next grant goes to ch0.
REQ-041 SHALL cover stall: rdy_in=0 for 3 cycles with 2 pending entries -> no broadcast and no push; after resume both broadcast in round-robin order.
REQ-042 SHALL cover async reset mid-stream: rst_n_in=0 asserted between edges -> cdb_valid=0 immediately, and pending results are never broadcast.
